fifo_stream2native: RTL and testbench
=====================================

FIFO_STREAM2NATIVE -- requirements
Module: fifo_stream2native

Interface
REQ-001 Parameter DATA_WIDTH, 256, width of stream data and FIFO din.
REQ-002 Parameter CNT_WIDTH, 32, width of the written-beat counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 s_axis_tvalid  input  1  upstream beat valid.
REQ-007 s_axis_tready  output  1  block can accept a beat; driven directly from a register.
REQ-008 s_axis_tdata  input  DATA_WIDTH  upstream beat data.
REQ-009 full  input  1  native FIFO write-side full flag.
REQ-010 wr_en  output  1  native FIFO write strobe.
REQ-011 din  output  DATA_WIDTH  native FIFO write data.
REQ-012 cnt_clr  input  1  synchronous clear of beat_cnt.
REQ-013 beat_cnt  output  CNT_WIDTH  number of beats written to the FIFO since reset/clear.

Function
REQ-014 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1 at a rising edge.
REQ-015 Storage SHALL be two entries: a main register (drives din) and a skid register.
REQ-016 State machine SHALL have states EMPTY (0 held), ONE (main valid), TWO (main and skid valid).
REQ-017 wr_en SHALL equal main_valid AND NOT full, combinationally; wr_en SHALL never be 1 while full is 1.
REQ-018 din SHALL equal the main register contents; din SHALL be stable while main_valid and full are both 1.
REQ-019 EMPTY: accept -> ONE, data into main; no accept -> EMPTY.
REQ-020 ONE: accept and wr_en -> ONE, new data into main; accept and no wr_en -> TWO, new data into skid; wr_en only -> EMPTY; neither -> ONE.
REQ-021 TWO: wr_en -> ONE, skid moves to main; no wr_en -> TWO; no accept possible.
REQ-022 s_axis_tready SHALL be registered as 1 when next state is EMPTY or ONE, 0 when next state is TWO.
REQ-023 Latency: a beat accepted at edge N SHALL appear on din with wr_en=1 in the cycle after edge N when full=0 and it is the oldest held beat.
REQ-024 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-025 With full held 0 and tvalid held 1, throughput SHALL be one beat per cycle.
REQ-026 beat_cnt SHALL increment by 1 on each edge where wr_en=1, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-027 cnt_clr=1 SHALL set beat_cnt to 0 at the next edge, overriding a simultaneous wr_en increment.
REQ-028 s_axis_tdata SHALL be ignored when no accept occurs; upstream may drop tvalid at any time without effect.

Reset
REQ-029 On rst=1: state EMPTY, main_valid=0, skid_valid=0, s_axis_tready=0, beat_cnt=0, main and skid data 0 (so wr_en=0, din=0).
REQ-030 s_axis_tready SHALL rise to 1 on the first clock edge after rst deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard held beats; no wr_en SHALL occur during reset.

Structure
REQ-032 State encoding localparams (EMPTY=2'b00, ONE=2'b01, TWO=2'b10) SHALL live in a shared package with the native/stream converter states.
REQ-033 The two-entry buffer MAY be a sub-module named axis_skid_buf; beat counter stays in the top module.

Verification
REQ-034 Reset: rst=1 for 3 cycles with tvalid=1 -> tready=0, wr_en=0, beat_cnt=0; tready=1 one edge after release.
REQ-035 Streaming: full=0, 8 beats 0x01..0x08 back-to-back -> wr_en=1 for 8 consecutive cycles, din 0x01..0x08 in order, beat_cnt=8.
REQ-036 Back-pressure: full=1 while 3 beats offered -> 2 accepted, tready=0 after second; full=0 -> din 0xA1, 0xA2, then third beat 0xA3 accepted and written, none lost.
REQ-037 Full toggling every cycle with random tvalid, 1000 beats -> scoreboard order match, wr_en never with full=1, beat_cnt=1000.
REQ-038 Counter: preload via 2^32-1 writes (or forced) then one write -> beat_cnt=0; cnt_clr with simultaneous wr_en -> beat_cnt=0.
REQ-039 Mid-operation reset in state TWO -> both entries discarded, first post-reset beat 0x55 is the next din.

Source files
------------

// File: rtl/fifo_stream2native_pkg.sv
// Shared definitions for the stream/native FIFO adapters: state encodings
// and small helpers used by the buffer control logic.
package fifo_stream2native_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    // Stream-to-native two-entry buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        TWO   = ST_TWO
    } buf_state_t;

    // Native-to-stream converter states (companion block).
    typedef enum logic [1:0] {
        N2S_IDLE = 2'b00,
        N2S_READ = 2'b01,
        N2S_HOLD = 2'b10
    } n2s_state_t;

    // Upstream may be offered a slot whenever the skid entry is free.
    function automatic logic tready_for(input buf_state_t st);
        return (st != TWO);
    endfunction

endpackage

// File: rtl/fifo_stream2native_if.sv
// Stream input and native FIFO write-side signals of the adapter.
interface fifo_stream2native_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  full;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        input  full,
        output s_axis_tready,
        output wr_en,
        output din
    );

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        output full,
        input  s_axis_tready,
        input  wr_en,
        input  din
    );
endinterface

// File: rtl/fifo_stream2native_skid_buf.sv
// Two-entry skid buffer: main entry feeds the FIFO write port, skid entry
// absorbs the beat that arrives while the FIFO is full.
module axis_skid_buf
    import fifo_stream2native_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] dout
);

    buf_state_t            state_r;
    buf_state_t            state_nxt_s;
    logic                  main_valid_r;
    logic                  tready_r;
    logic [DATA_WIDTH-1:0] main_r;
    logic [DATA_WIDTH-1:0] skid_r;
    logic                  accept_s;
    logic                  pop_s;
    logic                  load_main_in_s;
    logic                  load_main_skid_s;
    logic                  load_skid_s;

    assign accept_s = s_valid & tready_r;
    assign pop_s    = main_valid_r & ~full;
    assign wr_en    = pop_s;
    assign dout     = main_r;
    assign s_ready  = tready_r;

    // Next-state and entry-load decode.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s    = ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && pop_s) begin
                    state_nxt_s    = ONE;
                    load_main_in_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = TWO;
                    load_skid_s = 1'b1;
                end else if (pop_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                if (pop_s) begin
                    state_nxt_s      = ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State, main-valid and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= EMPTY;
            main_valid_r <= 1'b0;
            tready_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            main_valid_r <= (state_nxt_s != EMPTY);
            tready_r     <= tready_for(state_nxt_s);
        end
    end

    // Entry data registers; main only changes on a load, keeping din stable under full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r <= {DATA_WIDTH{1'b0}};
            skid_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_r <= s_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= s_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

endmodule

// File: rtl/fifo_stream2native.sv
// Stream-to-native FIFO write adapter with a running count of written beats.
module fifo_stream2native
    import fifo_stream2native_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream2native_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] beat_cnt
);

    logic                 wr_en_s;
    logic [CNT_WIDTH-1:0] beat_cnt_r;

    axis_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .s_valid (bus.s_axis_tvalid),
        .s_ready (bus.s_axis_tready),
        .s_data  (bus.s_axis_tdata),
        .full    (bus.full),
        .wr_en   (wr_en_s),
        .dout    (bus.din)
    );

    assign bus.wr_en = wr_en_s;
    assign beat_cnt  = beat_cnt_r;

    // Written-beat counter; clear wins over a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_clr) begin
            beat_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (wr_en_s) begin
            beat_cnt_r <= beat_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

endmodule

// File: tb/tb_fifo_stream2native.sv
// Directed bench for fifo_stream2native: vector table plus multi-cycle sequences.
module tb_fifo_stream2native;
    import fifo_stream2native_pkg::*;

    typedef struct {
        logic         tvalid;
        logic [255:0] tdata;
        logic         full;
        logic         clr;
        logic         e_tready;
        logic         e_wr_en;
        logic [255:0] e_din;
        logic [31:0]  e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_clr;
    logic [31:0] beat_cnt;
    logic        cnt_clr_w;
    logic [3:0]  beat_cnt_w;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    fifo_stream2native_if #(.DATA_WIDTH(256)) b ();
    fifo_stream2native_if #(.DATA_WIDTH(256)) bw ();

    fifo_stream2native #(.DATA_WIDTH(256), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .bus(b), .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
    );

    fifo_stream2native #(.DATA_WIDTH(256), .CNT_WIDTH(4)) u_dut_w (
        .clk(clk), .rst(rst), .bus(bw), .cnt_clr(cnt_clr_w), .beat_cnt(beat_cnt_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic tv, input logic [255:0] td, input logic fu, input logic cl,
                       input logic er, input logic ew, input logic [255:0] ed, input logic [31:0] ec);
        vec_t v;
        v.tvalid = tv; v.tdata = td; v.full = fu; v.clr = cl;
        v.e_tready = er; v.e_wr_en = ew; v.e_din = ed; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] q[$];
        logic [255:0] cur;
        logic [255:0] exp_d;
        logic         full_t;
        int sent, rcvd, viol, cyc;

        // Streaming: 8 back-to-back beats, then drain.
        for (int i = 0; i < 8; i++)
            add(1'b1, 256'(i + 1), 1'b0, 1'b0, 1'b1, (i > 0),
                (i == 0) ? 256'h0 : 256'(i), (i == 0) ? 32'h0 : 32'(i - 1));
        add(1'b0, 256'h0,    1'b0, 1'b0, 1'b1, 1'b1, 256'h8,  32'd7);
        add(1'b0, 256'h0,    1'b0, 1'b0, 1'b1, 1'b0, 256'h8,  32'd8);
        // Back-pressure: two beats absorbed, third held off until full drops.
        add(1'b1, 256'hA1,   1'b1, 1'b0, 1'b1, 1'b0, 256'h8,  32'd8);
        add(1'b1, 256'hA2,   1'b1, 1'b0, 1'b1, 1'b0, 256'hA1, 32'd8);
        add(1'b1, 256'hA3,   1'b1, 1'b0, 1'b0, 1'b0, 256'hA1, 32'd8);
        add(1'b1, 256'hA3,   1'b1, 1'b0, 1'b0, 1'b0, 256'hA1, 32'd8);
        add(1'b1, 256'hA3,   1'b0, 1'b0, 1'b0, 1'b1, 256'hA1, 32'd8);
        add(1'b1, 256'hA3,   1'b0, 1'b0, 1'b1, 1'b1, 256'hA2, 32'd9);
        // Clear coinciding with a write, then idle data that must be ignored.
        add(1'b0, 256'hDEAD, 1'b0, 1'b1, 1'b1, 1'b1, 256'hA3, 32'd10);
        add(1'b0, 256'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 256'hA3, 32'd0);

        cnt_clr = 1'b0; cnt_clr_w = 1'b0;
        bw.s_axis_tvalid = 1'b0; bw.s_axis_tdata = 256'h0; bw.full = 1'b0;
        b.s_axis_tvalid = 1'b1; b.s_axis_tdata = 256'hFF; b.full = 1'b0;

        // Reset held for three cycles with tvalid asserted.
        repeat (3) tick();
        chk("rst_tready", 256'(b.s_axis_tready), 256'h0);
        chk("rst_wr_en",  256'(b.wr_en), 256'h0);
        chk("rst_cnt",    256'(beat_cnt), 256'h0);
        chk("rst_din",    b.din, 256'h0);
        rst = 1'b0;
        b.s_axis_tvalid = 1'b0;
        #1;
        chk("rel_tready_pre", 256'(b.s_axis_tready), 256'h0);
        tick();
        chk("rel_tready_post", 256'(b.s_axis_tready), 256'h1);
        chk("rel_wr_en", 256'(b.wr_en), 256'h0);

        foreach (vecs[i]) begin
            b.s_axis_tvalid = vecs[i].tvalid;
            b.s_axis_tdata  = vecs[i].tdata;
            b.full          = vecs[i].full;
            cnt_clr         = vecs[i].clr;
            #1;
            chk($sformatf("vec%0d_tready", i), 256'(b.s_axis_tready), 256'(vecs[i].e_tready));
            chk($sformatf("vec%0d_wr_en", i),  256'(b.wr_en), 256'(vecs[i].e_wr_en));
            chk($sformatf("vec%0d_din", i),    b.din, vecs[i].e_din);
            chk($sformatf("vec%0d_cnt", i),    256'(beat_cnt), 256'(vecs[i].e_cnt));
            tick();
        end
        cnt_clr = 1'b0;

        // Full toggling every cycle with random tvalid, scoreboard on order.
        sent = 0; rcvd = 0; viol = 0; cyc = 0;
        full_t = 1'b0;
        cur = rnd256();
        while (rcvd < 1000 && cyc < 20000) begin
            b.full = full_t;
            full_t = ~full_t;
            b.s_axis_tvalid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            b.s_axis_tdata  = b.s_axis_tvalid ? cur : rnd256();
            #1;
            if (b.wr_en && b.full) viol++;
            if (b.wr_en) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rand_extra_write: got %0h expected no write", b.din);
                end else begin
                    exp_d = q.pop_front();
                    chk($sformatf("rand_beat%0d", rcvd), b.din, exp_d);
                end
                rcvd++;
            end
            if (b.s_axis_tvalid && b.s_axis_tready) begin
                q.push_back(cur);
                sent++;
                cur = rnd256();
            end
            tick();
            cyc++;
        end
        b.s_axis_tvalid = 1'b0;
        b.full = 1'b0;
        chk("rand_rcvd", 256'(rcvd), 256'd1000);
        chk("rand_full_viol", 256'(viol), 256'd0);
        chk("rand_cnt", 256'(beat_cnt), 256'd1000);
        #1;
        chk("rand_idle_wr_en", 256'(b.wr_en), 256'h0);

        // Counter wrap on a 4-bit instance streaming continuously.
        bw.s_axis_tvalid = 1'b1;
        bw.s_axis_tdata  = 256'h77;
        tick();
        repeat (15) tick();
        chk("wrap_cnt_max", 256'(beat_cnt_w), 256'd15);
        chk("wrap_wr_en", 256'(bw.wr_en), 256'h1);
        tick();
        chk("wrap_cnt_zero", 256'(beat_cnt_w), 256'd0);
        bw.s_axis_tvalid = 1'b0;

        // Reset in state TWO discards both held beats.
        b.full = 1'b1;
        b.s_axis_tvalid = 1'b1;
        b.s_axis_tdata = 256'h11;
        tick();
        b.s_axis_tdata = 256'h22;
        tick();
        #1;
        chk("mr_two_tready", 256'(b.s_axis_tready), 256'h0);
        chk("mr_two_din", b.din, 256'h11);
        b.full = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_rst_wr_en", 256'(b.wr_en), 256'h0);
        chk("mr_rst_din", b.din, 256'h0);
        chk("mr_rst_cnt", 256'(beat_cnt), 256'h0);
        tick();
        tick();
        chk("mr_hold_wr_en", 256'(b.wr_en), 256'h0);
        chk("mr_hold_tready", 256'(b.s_axis_tready), 256'h0);
        rst = 1'b0;
        b.s_axis_tdata = 256'h55;
        b.s_axis_tvalid = 1'b1;
        tick();
        chk("mr_rel_tready", 256'(b.s_axis_tready), 256'h1);
        chk("mr_rel_wr_en", 256'(b.wr_en), 256'h0);
        tick();
        b.s_axis_tvalid = 1'b0;
        #1;
        chk("mr_first_wr_en", 256'(b.wr_en), 256'h1);
        chk("mr_first_din", b.din, 256'h55);
        tick();
        chk("mr_after_wr_en", 256'(b.wr_en), 256'h0);
        chk("mr_after_cnt", 256'(beat_cnt), 256'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
